// File: rtl/rcn_uart_fifo.sv
// Byte buffering between the RCN UART bus logic and the ser/des framer:
// a show-ahead tx FIFO feeding the framer handshake and an rx FIFO holding data plus frame error.
module rcn_uart_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    input  logic                  tx_push,
    input  logic [7:0]            tx_push_data,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  fr_tx_vld,
    output logic [7:0]            fr_tx_data,
    input  logic                  fr_tx_busy,
    input  logic                  fr_rx_vld,
    input  logic [7:0]            fr_rx_data,
    input  logic                  fr_rx_frame_error,
    input  logic                  rx_pop,
    output logic [8:0]            rx_pop_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_overflow,
    input  logic                  rx_overflow_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            tx_mem_r [DEPTH];
    logic [8:0]            rx_mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [DEPTH_LOG2:0]   tx_count_r, rx_count_r;
    logic                  rx_overflow_r;

    logic tx_empty_s, rx_full_s;
    logic tx_push_ok_s, tx_pop_ok_s, rx_push_ok_s, rx_pop_ok_s;

    // Flags and handshake qualifiers, all derived from registered counts
    always_comb begin
        tx_empty_s   = (tx_count_r == '0);
        rx_full_s    = (rx_count_r == FULL_CNT);
        tx_push_ok_s = tx_push && (tx_count_r != FULL_CNT);
        tx_pop_ok_s  = !tx_empty_s && !fr_tx_busy;
        rx_pop_ok_s  = rx_pop && (rx_count_r != '0);
        // A full rx FIFO still takes a byte when the host frees a slot in the same cycle
        rx_push_ok_s = fr_rx_vld && (!rx_full_s || rx_pop_ok_s);
    end

    assign tx_full     = (tx_count_r == FULL_CNT);
    assign tx_count    = tx_count_r;
    assign fr_tx_vld   = !tx_empty_s;
    assign fr_tx_data  = tx_mem_r[tx_rd_ptr_r];
    assign rx_pop_data = rx_mem_r[rx_rd_ptr_r];
    assign rx_empty    = (rx_count_r == '0);
    assign rx_count    = rx_count_r;
    assign rx_overflow = rx_overflow_r;

    // Tx storage write; contents are intentionally not reset
    always_ff @(posedge clk_50) begin
        if (tx_push_ok_s) begin
            tx_mem_r[tx_wr_ptr_r] <= tx_push_data;
        end
    end

    // Rx storage write; contents are intentionally not reset
    always_ff @(posedge clk_50) begin
        if (rx_push_ok_s) begin
            rx_mem_r[rx_wr_ptr_r] <= {fr_rx_frame_error, fr_rx_data};
        end
    end

    // Tx pointers and occupancy
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_count_r  <= '0;
        end else begin
            if (tx_push_ok_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end
            if (tx_pop_ok_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            case ({tx_push_ok_s, tx_pop_ok_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Rx pointers, occupancy and sticky overflow (set wins over clear)
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_r   <= '0;
            rx_rd_ptr_r   <= '0;
            rx_count_r    <= '0;
            rx_overflow_r <= 1'b0;
        end else begin
            if (rx_push_ok_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            end
            if (rx_pop_ok_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
            case ({rx_push_ok_s, rx_pop_ok_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
            if (fr_rx_vld && !rx_push_ok_s) begin
                rx_overflow_r <= 1'b1;
            end else if (rx_overflow_clr) begin
                rx_overflow_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rcn_uart_fifo.sv
// Scoreboard bench for rcn_uart_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_rcn_uart_fifo;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       tx_push = 1'b0;
    logic [7:0] tx_push_data = 8'h00;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       fr_tx_vld;
    logic [7:0] fr_tx_data;
    logic       fr_tx_busy = 1'b1;
    logic       fr_rx_vld = 1'b0;
    logic [7:0] fr_rx_data = 8'h00;
    logic       fr_rx_frame_error = 1'b0;
    logic       rx_pop = 1'b0;
    logic [8:0] rx_pop_data;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_overflow;
    logic       rx_overflow_clr = 1'b0;

    int compared = 0;
    int mismatched = 0;

    // Reference state: FIFO contents as queues, and scoreboards of expected outputs
    logic [7:0] tx_q[$];
    logic [8:0] rx_q[$];
    logic [7:0] exp_tx[$];
    logic [8:0] exp_rx[$];
    logic       ovf_m = 1'b0;

    rcn_uart_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .tx_push(tx_push), .tx_push_data(tx_push_data),
        .tx_full(tx_full), .tx_count(tx_count),
        .fr_tx_vld(fr_tx_vld), .fr_tx_data(fr_tx_data), .fr_tx_busy(fr_tx_busy),
        .fr_rx_vld(fr_rx_vld), .fr_rx_data(fr_rx_data), .fr_rx_frame_error(fr_rx_frame_error),
        .rx_pop(rx_pop), .rx_pop_data(rx_pop_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .rx_overflow_clr(rx_overflow_clr)
    );

    always #10 clk_50 = ~clk_50;

    function automatic void check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: apply the FIFO rules to the queues at every clock edge
    always @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_q.delete(); rx_q.delete(); exp_tx.delete(); exp_rx.delete();
            ovf_m = 1'b0;
        end else begin
            bit tx_pop_ok, tx_push_ok, rx_pop_ok, rx_push_ok;
            tx_pop_ok  = (tx_q.size() > 0) && !fr_tx_busy;
            tx_push_ok = tx_push && (tx_q.size() < 16);
            rx_pop_ok  = rx_pop && (rx_q.size() > 0);
            rx_push_ok = fr_rx_vld && ((rx_q.size() < 16) || rx_pop_ok);
            if (tx_pop_ok) void'(tx_q.pop_front());
            if (tx_push_ok) begin
                tx_q.push_back(tx_push_data);
                exp_tx.push_back(tx_push_data);
            end
            if (rx_pop_ok) void'(rx_q.pop_front());
            if (rx_push_ok) begin
                rx_q.push_back({fr_rx_frame_error, fr_rx_data});
                exp_rx.push_back({fr_rx_frame_error, fr_rx_data});
            end
            if (fr_rx_vld && !rx_push_ok) ovf_m = 1'b1;
            else if (rx_overflow_clr) ovf_m = 1'b0;
        end
    end

    // Monitor: sample on the falling edge, pop scoreboards on each handshake
    always @(negedge clk_50) begin
        if (rst_n) begin
            check("tx_count", int'(tx_count), tx_q.size());
            check("tx_full", int'(tx_full), int'(tx_q.size() == 16));
            check("fr_tx_vld", int'(fr_tx_vld), int'(tx_q.size() != 0));
            check("rx_count", int'(rx_count), rx_q.size());
            check("rx_empty", int'(rx_empty), int'(rx_q.size() == 0));
            check("rx_overflow", int'(rx_overflow), int'(ovf_m));
            if (fr_tx_vld && !fr_tx_busy) begin
                if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                else check("fr_tx_data", int'(fr_tx_data), int'(exp_tx.pop_front()));
            end
            if (rx_pop && !rx_empty) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_pop_data", int'(rx_pop_data), int'(exp_rx.pop_front()));
            end
        end
    end

    task automatic step(input bit push, input logic [7:0] d, input bit busy,
                        input bit rv, input logic [7:0] rd, input bit re,
                        input bit pop, input bit clr);
        tx_push = push; tx_push_data = d; fr_tx_busy = busy;
        fr_rx_vld = rv; fr_rx_data = rd; fr_rx_frame_error = re;
        rx_pop = pop; rx_overflow_clr = clr;
        @(posedge clk_50); #1;
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, busy, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_check();
        check("rst_tx_count", int'(tx_count), 0);
        check("rst_rx_count", int'(rx_count), 0);
        check("rst_rx_empty", int'(rx_empty), 1);
        check("rst_fr_tx_vld", int'(fr_tx_vld), 0);
        check("rst_tx_full", int'(tx_full), 0);
        check("rst_rx_overflow", int'(rx_overflow), 0);
    endtask

    initial begin
        #35; reset_check();
        @(posedge clk_50); #1; rst_n = 1'b1;
        idle(2, 1'b0);

        // Single byte straight through to the framer
        step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Fill tx while busy, drop the 17th byte, then drain across the pointer wrap
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idle(1, 1'b0);
            idle(2, 1'b1);
        end
        idle(2, 1'b0);

        // Two rx bytes with differing frame-error flags, then pop both
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);

        // Rx overflow: fill, drop, set-beats-clear, clear alone
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h40 + i), i[0], 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Full rx accepts a byte alongside a pop, then drain and pop while empty
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        // Empty rx with push and pop together: pop ignored, push kept
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);

        // Asynchronous reset with both FIFOs holding bytes
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        #3; rst_n = 1'b0; #1;
        reset_check();
        @(posedge clk_50); #1; rst_n = 1'b1;
        idle(1, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 45), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
        end
        idle(40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rcn_uart_fifo.md
Name: rcn_uart_fifo

Overview:
Byte buffering stage between the RCN UART register/bus logic and the UART ser/des framer.
- Tx FIFO accepts bytes from the host and drains them into the framer's tx_vld/tx_busy handshake.
- Rx FIFO captures each byte the framer delivers, together with its frame-error flag, for later host pops.
- Decouples bus access timing from the 115200-baud line rate.

Parameters:
DEPTH_LOG2, 4, log2 of entries per FIFO (16 entries each); both FIFOs are the same depth.

Ports:
clk_50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous reset, active-low
tx_push  in  1  host writes tx_push_data into tx FIFO
tx_push_data  in  8  byte to transmit
tx_full  out  1  tx FIFO holds 2^DEPTH_LOG2 entries
tx_count  out  DEPTH_LOG2+1  tx FIFO occupancy
fr_tx_vld  out  1  to framer tx_vld
fr_tx_data  out  8  to framer tx_data
fr_tx_busy  in  1  from framer tx_busy
fr_rx_vld  in  1  from framer rx_vld, single-cycle pulse
fr_rx_data  in  8  from framer rx_data
fr_rx_frame_error  in  1  from framer rx_frame_error, valid in the fr_rx_vld cycle
rx_pop  in  1  host consumes rx head entry
rx_pop_data  out  9  rx head: bit 8 = frame error, bits 7:0 = data
rx_empty  out  1  rx FIFO has no entries
rx_count  out  DEPTH_LOG2+1  rx FIFO occupancy
rx_overflow  out  1  sticky: an rx byte was dropped
rx_overflow_clr  in  1  clears rx_overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pointers and counts go to 0.
  - tx_full=0, fr_tx_vld=0, rx_empty=1, rx_overflow=0.
  - FIFO storage is not reset.
  - Reset mid-operation discards all queued bytes. A byte already accepted by the framer completes on the line.
- Storage: two independent circular buffers of 2^DEPTH_LOG2 x 8 (tx) and 2^DEPTH_LOG2 x 9 (rx).
  - Read and write pointers are DEPTH_LOG2 bits and wrap naturally from 2^DEPTH_LOG2-1 to 0.
  - Each FIFO has a separate occupancy counter, DEPTH_LOG2+1 bits.
- Flags: full = (count == 2^DEPTH_LOG2) and empty = (count == 0). Both are derived from registered counts.
- Tx push: when tx_push && !tx_full, write tx_push_data at the write pointer and advance it.
  - A push while tx_full is dropped silently, even if a pop occurs in the same cycle; no flag is raised.
- Tx drain:
  - fr_tx_vld = !tx_empty; fr_tx_data = tx head (show-ahead).
  - Transfer occurs in a cycle where fr_tx_vld && !fr_tx_busy. The tx read pointer advances in that cycle.
  - The framer raises fr_tx_busy on the following cycle, which prevents a double accept.
  - No other pop source exists.
- Tx latency: push at cycle N into an empty FIFO gives fr_tx_vld=1 with that byte at N+1. If fr_tx_busy=0, it is accepted at N+1.
- Simultaneous tx push and drain: count is unchanged. The push is accepted only if tx_full was 0 at that edge.
- Rx capture: on fr_rx_vld, write {fr_rx_frame_error, fr_rx_data} into the rx FIFO.
  - Accepted if !rx_full, or if rx_full and rx_pop && !rx_empty occur in the same cycle (count unchanged).
  - Otherwise the byte is dropped and rx_overflow is set on the next edge.
- rx_overflow: set has priority over rx_overflow_clr in the same cycle. It is cleared by rx_overflow_clr alone.
- Rx pop: rx_pop && !rx_empty advances the rx read pointer.
  - rx_pop while empty is ignored; no state change.
  - rx_pop_data is combinational from the head entry, valid only while !rx_empty; don't-care when empty.
- Rx latency: fr_rx_vld at cycle N into an empty FIFO gives rx_empty=0 and valid rx_pop_data at N+1.
- Empty rx FIFO receiving fr_rx_vld and rx_pop in the same cycle: the pop is ignored and the push proceeds.
- Counts: increment on accepted push only, decrement on accepted pop only, unchanged on both or neither. A count never exceeds 2^DEPTH_LOG2.

Test Plan:
- Reset, then push 0x55, fr_tx_busy=0 -> fr_tx_vld=1 with fr_tx_data=0x55 at next cycle, accepted. tx_count returns 0 one cycle later. fr_tx_vld stays 0 with no further pushes.
- Hold fr_tx_busy=1, push 17 bytes 0x00..0x10 -> tx_full=1 after 16 pushes, 0x10 dropped, tx_count=16. Release busy each byte -> framer sees 0x00..0x0F in order, across pointer wrap.
- Pulse fr_rx_vld with 0xA5/err=0, then 0x3C/err=1 -> rx_pop_data=0x0A5 and rx_count=2. After pop, rx_pop_data=0x13C. After second pop, rx_empty=1.
- Fill rx with 16 bytes, pulse fr_rx_vld with 0x77 (no pop) -> byte dropped, rx_overflow=1, count=16. Assert rx_overflow_clr and fr_rx_vld overflow in the same cycle -> rx_overflow stays 1. rx_overflow_clr alone -> 0.
- Rx full, fr_rx_vld=0x99 with rx_pop in the same cycle -> count stays 16, no overflow, 0x99 popped last. rx_pop while empty -> counts unchanged.
- Queue 4 tx and 4 rx bytes, assert rst_n low mid-transfer -> tx_count=rx_count=0, rx_empty=1, fr_tx_vld=0 immediately (asynchronous). Normal operation after release.
